// File: rtl/johnson_decoder.sv
// Johnson code receiver: decodes a WIDTH-bit twisted-ring code to its index, flags illegal
// codes and out-of-sequence steps, and tracks lock. JDEC_HOLD_ALLOW_EN accepts stalled codes.
module johnson_decoder #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LOCK_CNT  = 3,
  parameter int unsigned ERR_LIMIT = 2,
  parameter int unsigned CNT_W     = 8,
  localparam int unsigned SEQ      = 2 * WIDTH,
  localparam int unsigned IW       = $clog2(SEQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_code,
  input  logic             err_clr,
  output logic             out_valid,
  output logic [IW-1:0]    out_idx,
  output logic             out_legal,
  output logic             out_step_err,
  output logic             locked,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(ERR_LIMIT + 1);

  typedef enum logic [1:0] {StUnlocked, StAcquire, StLocked} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    ref_q, ref_d;
  logic [GW-1:0]    good_q, good_d;
  logic [BW-1:0]    bad_q, bad_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             out_valid_q, out_legal_q, out_step_q;
  logic [IW-1:0]    out_idx_q;

  int unsigned      pop;
  logic [WIDTH-1:0] lo_mask, hi_mask;
  logic             legal;
  logic [IW-1:0]    idx, exp_idx;
  logic             good_step, hold, step_err;
  logic [GW:0]      good_inc;
  logic [BW:0]      bad_inc;

  // A legal code is a run of pop ones anchored at either end of the word.
  always_comb begin
    pop = 0;
    for (int i = 0; i < WIDTH; i++) pop = pop + 32'(in_code[i]);
    for (int i = 0; i < WIDTH; i++) begin
      lo_mask[i] = (unsigned'(i) < pop);
      hi_mask[i] = (unsigned'(i) >= WIDTH - pop);
    end
    legal = (in_code == lo_mask) || (in_code == hi_mask);
    if (!legal) begin
      idx = '0;
    end else if (in_code[0] || (in_code == '0)) begin
      idx = IW'(pop);
    end else begin
      idx = IW'(SEQ - pop);
    end
  end

  always_comb begin
    exp_idx   = (ref_q == IW'(SEQ - 1)) ? '0 : ref_q + 1'b1;
    good_step = legal && (idx == exp_idx);
`ifdef JDEC_HOLD_ALLOW_EN
    hold      = legal && (idx == ref_q);
`else
    hold      = 1'b0;
`endif
  end

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    good_d   = good_q;
    bad_d    = bad_q;
    err_d    = err_q;
    step_err = 1'b0;
    good_inc = {1'b0, good_q} + 1'b1;
    bad_inc  = {1'b0, bad_q} + 1'b1;
    if (in_valid) begin
      case (state_q)
        StUnlocked: begin
          if (legal) begin
            ref_d   = idx;
            good_d  = GW'(1);
            state_d = (LOCK_CNT == 1) ? StLocked : StAcquire;
          end
        end
        StAcquire: begin
          if (!legal) begin
            state_d = StUnlocked;
            good_d  = '0;
          end else if (good_step) begin
            ref_d  = idx;
            good_d = good_inc[GW-1:0];
            if (good_inc >= (GW + 1)'(LOCK_CNT)) state_d = StLocked;
          end else if (!hold) begin
            // Resynchronise on the new code and restart acquisition from it.
            step_err = 1'b1;
            ref_d    = idx;
            good_d   = GW'(1);
          end
        end
        StLocked: begin
          if (good_step || hold) begin
            ref_d = idx;
            bad_d = '0;
          end else begin
            if (legal) begin
              step_err = 1'b1;
              ref_d    = idx;
            end
            if (err_q != '1) err_d = err_q + 1'b1;
            if (bad_inc >= (BW + 1)'(ERR_LIMIT)) begin
              state_d = StUnlocked;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              bad_d = bad_inc[BW-1:0];
            end
          end
        end
        default: state_d = StUnlocked;
      endcase
    end
    if (err_clr) err_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StUnlocked;
      ref_q       <= '0;
      good_q      <= '0;
      bad_q       <= '0;
      err_q       <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_legal_q <= 1'b0;
      out_step_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      err_q       <= err_d;
      out_valid_q <= in_valid;
      if (in_valid) out_idx_q <= idx;
      out_legal_q <= in_valid & legal;
      out_step_q  <= step_err;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_idx      = out_idx_q;
  assign out_legal    = out_legal_q;
  assign out_step_err = out_step_q;
  assign locked       = (state_q == StLocked);
  assign err_cnt      = err_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder (WIDTH=4, LOCK_CNT=3, ERR_LIMIT=2) with a result queue.
module tb_johnson_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_code = '0;
  logic       err_clr = 1'b0;
  logic       out_valid;
  logic [2:0] out_idx;
  logic       out_legal;
  logic       out_step_err;
  logic       locked;
  logic [7:0] err_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int idx;
    int legal;
    int step;
    int lock;
    int err;
  } exp_t;

  exp_t sb[$];

  johnson_decoder #(
    .WIDTH(4),
    .LOCK_CNT(3),
    .ERR_LIMIT(2),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_code(in_code),
    .err_clr(err_clr),
    .out_valid(out_valid),
    .out_idx(out_idx),
    .out_legal(out_legal),
    .out_step_err(out_step_err),
    .locked(locked),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 0);
    chk({tag, ".idx"}, 32'(out_idx), 0);
    chk({tag, ".legal"}, 32'(out_legal), 0);
    chk({tag, ".step"}, 32'(out_step_err), 0);
    chk({tag, ".lock"}, 32'(locked), 0);
    chk({tag, ".err"}, 32'(err_cnt), 0);
  endtask

  task automatic step(input string tag, input logic [3:0] code, input int idx, input int legal,
                      input int se, input int lk, input int ec, input logic clr = 1'b0);
    exp_t e;
    in_valid = 1'b1;
    in_code  = code;
    err_clr  = clr;
    sb.push_back('{idx, legal, se, lk, ec});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    err_clr  = 1'b0;
    chk({tag, ".valid"}, 32'(out_valid), 1);
    e = sb.pop_front();
    chk({tag, ".idx"}, 32'(out_idx), 32'(e.idx));
    chk({tag, ".legal"}, 32'(out_legal), 32'(e.legal));
    chk({tag, ".step"}, 32'(out_step_err), 32'(e.step));
    chk({tag, ".lock"}, 32'(locked), 32'(e.lock));
    chk({tag, ".err"}, 32'(err_cnt), 32'(e.err));
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Acquire lock on three consecutive codes
    step("t1_0000", 4'b0000, 0, 1, 0, 0, 0);
    step("t1_0001", 4'b0001, 1, 1, 0, 0, 0);
    step("t1_0011", 4'b0011, 2, 1, 0, 1, 0);

    // Two illegal codes drop lock
    step("t2_0101", 4'b0101, 0, 0, 0, 1, 1);
    step("t2_1010", 4'b1010, 0, 0, 0, 0, 2);

    // Relock through the upper half, then wrap 7 -> 0
    step("t3_0111", 4'b0111, 3, 1, 0, 0, 2);
    step("t3_1111", 4'b1111, 4, 1, 0, 0, 2);
    step("t3_1110", 4'b1110, 5, 1, 0, 1, 2);
    step("t3_1100", 4'b1100, 6, 1, 0, 1, 2);
    step("t3_1000", 4'b1000, 7, 1, 0, 1, 2);

    // Idle cycle: no flags, no state change
    @(posedge clk);
    #1;
    chk("idle.valid", 32'(out_valid), 0);
    chk("idle.legal", 32'(out_legal), 0);
    chk("idle.step", 32'(out_step_err), 0);
    chk("idle.lock", 32'(locked), 1);

    step("t3_0000", 4'b0000, 0, 1, 0, 1, 2);
    step("t3_0001", 4'b0001, 1, 1, 0, 1, 2);

    // Skip ahead: step error, then a good step clears the bad count
    step("t4_0111", 4'b0111, 3, 1, 1, 1, 3);
    step("t4_1111", 4'b1111, 4, 1, 0, 1, 3);
    step("t4_0101", 4'b0101, 0, 0, 0, 1, 4);
    step("t4_1110", 4'b1110, 5, 1, 0, 1, 4);

    // Walk to 0011, then repeat it
    step("t5_1100", 4'b1100, 6, 1, 0, 1, 4);
    step("t5_1000", 4'b1000, 7, 1, 0, 1, 4);
    step("t5_0000", 4'b0000, 0, 1, 0, 1, 4);
    step("t5_0001", 4'b0001, 1, 1, 0, 1, 4);
    step("t5_0011", 4'b0011, 2, 1, 0, 1, 4);
`ifdef JDEC_HOLD_ALLOW_EN
    step("t5_repeat", 4'b0011, 2, 1, 0, 1, 4);
`else
    step("t5_repeat", 4'b0011, 2, 1, 1, 1, 5);
`endif

    // Mid-stream reset with valid input present
    in_valid = 1'b1;
    in_code  = 4'b0111;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    chk_all_zero("t6_reset");

    // Relock, then error together with err_clr
    step("t6_0000", 4'b0000, 0, 1, 0, 0, 0);
    step("t6_0001", 4'b0001, 1, 1, 0, 0, 0);
    step("t6_0011", 4'b0011, 2, 1, 0, 1, 0);
    step("t6_clr", 4'b0101, 0, 0, 0, 1, 0, 1'b1);
    step("t6_err2", 4'b0101, 0, 0, 0, 0, 1);

    // Unlocked illegal code, then a bad step during acquisition
    step("t7_1010", 4'b1010, 0, 0, 0, 0, 1);
    step("t7_0000", 4'b0000, 0, 1, 0, 0, 1);
    step("t7_0011", 4'b0011, 2, 1, 1, 0, 1);
    step("t7_0111", 4'b0111, 3, 1, 0, 0, 1);
    step("t7_1111", 4'b1111, 4, 1, 0, 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
